// File: rtl/ud_counter_pkg.sv
// ud_counter_pkg: types and constants shared by the ud_counter_ctrl
// sequencer and the ud_counter_block digit counters.
package ud_counter_pkg;

  // Sequencer state encoding; values are fixed so state can be probed
  // and compared across blocks.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // Default number of inter_clk cycles per count tick.
  localparam int DEFAULT_PRESCALE = 4;

  // Width of one counter digit (shared with ud_counter_block).
  localparam int DIGIT_W = 4;

endpackage

// File: rtl/ud_tick_gen.sv
// ud_tick_gen: free-running prescaler that emits a one-cycle tick every
// PRESCALE enabled, unheld cycles. sclr restarts the count from zero.
module ud_tick_gen
  import ud_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int PSC_W    = 16
) (
  input  logic inter_clk,
  input  logic clr,
  input  logic en,
  input  logic hold,
  input  logic sclr,
  output logic tick
);

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

  logic [PSC_W-1:0] psc_reg;

  // Prescaler: clears on sclr, advances only when enabled and not held,
  // and wraps to zero after the last phase.
  always_ff @(posedge inter_clk or negedge clr) begin
    if (!clr) begin
      psc_reg <= '0;
    end else if (sclr) begin
      psc_reg <= '0;
    end else if (en && !hold) begin
      if (psc_reg == PSC_LAST) begin
        psc_reg <= '0;
      end else begin
        psc_reg <= psc_reg + PSC_W'(1);
      end
    end
  end

  // A held cycle never produces a tick, so pause cannot leak a count.
  assign tick = en & ~hold & (psc_reg == PSC_LAST);

endmodule

// File: rtl/ud_counter_ctrl.sv
// ud_counter_ctrl: initiator-side sequencer for a ud_counter_block chain.
// Loads the chain, paces count enables with ud_tick_gen and stops on
// terminal count, pulsing done for the game logic.
// Optional feature macro: UD_CTRL_AUTO_RELOAD_EN -- when defined, terminal
// count reloads the chain and the round runs until abort, counting wraps.
module ud_counter_ctrl
  import ud_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int PSC_W    = 16,
  parameter int WRAP_W   = 8
) (
  input  logic              inter_clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic              dir_up,
  input  logic              tc,
  output logic              ld,
  output logic              cnt,
  output logic              up,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);

  ctrl_state_t state_reg;
  logic        up_reg;
  logic        tick;
  logic        in_run;
  logic        accept_start;

  assign in_run       = (state_reg == RUN);
  assign accept_start = (state_reg == IDLE) & start & ~abort;

  // Prescaler restarts in LOAD so the first tick lands PRESCALE cycles
  // after entering RUN.
  ud_tick_gen #(
    .PRESCALE (PRESCALE),
    .PSC_W    (PSC_W)
  ) u_tick_gen (
    .inter_clk (inter_clk),
    .clr       (clr),
    .en        (in_run),
    .hold      (pause),
    .sclr      (state_reg == LOAD),
    .tick      (tick)
  );

  // Round sequencer; direction is latched only on an accepted start so
  // the tc polarity stays stable for the whole round.
  always_ff @(posedge inter_clk or negedge clr) begin
    if (!clr) begin
      state_reg <= IDLE;
      up_reg    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept_start) begin
            state_reg <= LOAD;
            up_reg    <= dir_up;
          end
        end
        LOAD: begin
          state_reg <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (tick && tc) begin
`ifdef UD_CTRL_AUTO_RELOAD_EN
            state_reg <= LOAD;
`else
            state_reg <= DONE;
`endif
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef UD_CTRL_AUTO_RELOAD_EN
  logic [WRAP_W-1:0] wraps_reg;

  // Wrap counter: cleared on an accepted start, bumped (saturating) on
  // every auto-reload, i.e. each terminal-count tick in RUN.
  always_ff @(posedge inter_clk or negedge clr) begin
    if (!clr) begin
      wraps_reg <= '0;
    end else if (accept_start) begin
      wraps_reg <= '0;
    end else if (in_run && !abort && tick && tc && (wraps_reg != {WRAP_W{1'b1}})) begin
      wraps_reg <= wraps_reg + WRAP_W'(1);
    end
  end

  assign wraps = wraps_reg;
`else
  assign wraps = '0;
`endif

  // Strobes decode from registered state; cnt is combinational on tc so
  // the counter rests on its terminal value instead of stepping past it.
  assign ld   = (state_reg == LOAD);
  assign busy = (state_reg == LOAD) | in_run;
  assign done = (state_reg == DONE);
  assign cnt  = in_run & tick & ~tc & ~abort;
  assign up   = up_reg;

endmodule

// File: tb/tb_ud_counter_ctrl.sv
// tb_ud_counter_ctrl: directed bench for ud_counter_ctrl. Three instances
// (PRESCALE 4, 2, 1) each drive a behavioural 4-bit digit counter.
module tb_ud_counter_ctrl;
  import ud_counter_pkg::*;

  logic inter_clk = 1'b0;
  logic clr = 1'b0;
  always #5 inter_clk = ~inter_clk;

  logic [2:0] start = '0, abort = '0, pause = '0, dir_up = '0;
  logic [2:0] tc, ld, cnt, up, busy, done;
  logic [2:0][7:0] wraps;
  logic [3:0] num [3];
  logic [3:0] val [3];

  int n_checks = 0;
  int n_fail   = 0;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int PS = (gi == 0) ? 4 : ((gi == 1) ? 2 : 1);
      ud_counter_ctrl #(.PRESCALE(PS), .PSC_W(16), .WRAP_W(8)) dut (
        .inter_clk (inter_clk),
        .clr       (clr),
        .start     (start[gi]),
        .abort     (abort[gi]),
        .pause     (pause[gi]),
        .dir_up    (dir_up[gi]),
        .tc        (tc[gi]),
        .ld        (ld[gi]),
        .cnt       (cnt[gi]),
        .up        (up[gi]),
        .busy      (busy[gi]),
        .done      (done[gi]),
        .wraps     (wraps[gi])
      );
    end
  endgenerate

  // Behavioural single-digit up/down counter with load, per instance
  always @(posedge inter_clk or negedge clr) begin
    for (int i = 0; i < 3; i++) begin
      if (!clr) val[i] <= 4'd0;
      else if (ld[i]) val[i] <= num[i];
      else if (cnt[i]) val[i] <= up[i] ? val[i] + 4'd1 : val[i] - 4'd1;
    end
  end

  always_comb begin
    tc = '0;
    for (int i = 0; i < 3; i++) tc[i] = up[i] ? (val[i] == 4'd15) : (val[i] == 4'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge inter_clk);
    #1;
  endtask

  // Round statistics filled by run_round
  int ld_n, ld_cyc, cnt_n, first_cnt, last_cnt, done_n, done_cyc;
  int cnt_in_pause, gap_bad, up_bad, busy_after_abort;

  // Start a round on instance i at cycle 0 and watch it for n_cyc cycles.
  task automatic run_round(input int i, input int n_cyc, input int p_from, input int p_to,
                           input int ab_at, input int exp_gap, input logic exp_up);
    int prev;
    ld_n = 0; ld_cyc = -1; cnt_n = 0; first_cnt = -1; last_cnt = -1;
    done_n = 0; done_cyc = -1; cnt_in_pause = 0; gap_bad = 0; up_bad = 0;
    busy_after_abort = -1; prev = -1;
    for (int c = 0; c <= n_cyc; c++) begin
      start[i] = (c == 0);
      pause[i] = (c >= p_from) && (c <= p_to);
      abort[i] = (c == ab_at);
      #1;
      if (ld[i]) begin ld_n++; if (ld_cyc < 0) ld_cyc = c; end
      if (cnt[i]) begin
        cnt_n++;
        if (first_cnt < 0) first_cnt = c;
        last_cnt = c;
        if (pause[i]) cnt_in_pause++;
        if (prev >= 0 && (c - prev) != exp_gap) gap_bad++;
        prev = c;
      end
      if (done[i]) begin done_n++; done_cyc = c; end
      if (c == ab_at + 1) busy_after_abort = busy[i];
      if (c >= 1 && up[i] !== exp_up) up_bad++;
      step();
    end
    start[i] = 1'b0; pause[i] = 1'b0; abort[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) num[i] = 4'd0;
    clr = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy%0d", i), busy[i], 0);
      check($sformatf("rst_ld%0d", i), ld[i], 0);
      check($sformatf("rst_cnt%0d", i), cnt[i], 0);
      check($sformatf("rst_done%0d", i), done[i], 0);
      check($sformatf("rst_up%0d", i), up[i], 1);
      check($sformatf("rst_wraps%0d", i), wraps[i], 0);
    end
    clr = 1'b1;
    step();

`ifndef UD_CTRL_AUTO_RELOAD_EN
    // Count-up round, PRESCALE=4, num=1
    num[0] = 4'd1; dir_up[0] = 1'b1;
    run_round(0, 70, 999, 999, 999, 4, 1'b1);
    check("up_ld_n", ld_n, 1);
    check("up_ld_cyc", ld_cyc, 1);
    check("up_cnt_n", cnt_n, 14);
    check("up_first_cnt", first_cnt, 5);
    check("up_last_cnt", last_cnt, 57);
    check("up_gap_bad", gap_bad, 0);
    check("up_done_n", done_n, 1);
    check("up_done_cyc", done_cyc, 62);
    check("up_val", val[0], 15);
    check("up_busy_end", busy[0], 0);
    check("up_up_bad", up_bad, 0);
    check("up_wraps", wraps[0], 0);

    // Count-down with pause, PRESCALE=2, num=1
    num[1] = 4'd1; dir_up[1] = 1'b0;
    run_round(1, 25, 4, 13, 999, 2, 1'b0);
    check("dn_cnt_n", cnt_n, 1);
    check("dn_first_cnt", first_cnt, 3);
    check("dn_cnt_in_pause", cnt_in_pause, 0);
    check("dn_done_cyc", done_cyc, 16);
    check("dn_val", val[1], 0);
    check("dn_up_bad", up_bad, 0);
    check("dn_up_held", up[1], 0);

    // PRESCALE=1 with the counter already at terminal
    num[2] = 4'd15; dir_up[2] = 1'b1;
    run_round(2, 8, 999, 999, 999, 1, 1'b1);
    check("p1_ld_cyc", ld_cyc, 1);
    check("p1_cnt_n", cnt_n, 0);
    check("p1_done_cyc", done_cyc, 3);
    check("p1_val", val[2], 15);
`endif

    // Abort after the third cnt, PRESCALE=4, num=2
    num[0] = 4'd2; dir_up[0] = 1'b1;
    run_round(0, 70, 999, 999, 14, 4, 1'b1);
    check("ab_cnt_n", cnt_n, 3);
    check("ab_last_cnt", last_cnt, 13);
    check("ab_done_n", done_n, 0);
    check("ab_busy_next", busy_after_abort, 0);
    check("ab_val", val[0], 5);

    // start and abort together in IDLE
    dir_up[0] = 1'b0; start[0] = 1'b1; abort[0] = 1'b1;
    step();
    start[0] = 1'b0; abort[0] = 1'b0;
    #1;
    check("coll_busy", busy[0], 0);
    check("coll_ld", ld[0], 0);
    check("coll_up", up[0], 1);
    step(); step();
    check("coll_busy2", busy[0], 0);

`ifdef UD_CTRL_AUTO_RELOAD_EN
    // Auto-reload: PRESCALE=1, num=13 -> LOAD + two cnts per wrap
    begin
      int ar_done, ar_idle, ar_cnt, ar_ld;
      ar_done = 0; ar_idle = 0; ar_cnt = 0; ar_ld = 0;
      num[2] = 4'd13; dir_up[2] = 1'b1;
      for (int c = 0; c <= 21; c++) begin
        start[2] = (c == 0);
        abort[2] = (c == 21);
        #1;
        if (done[2]) ar_done++;
        if (c >= 1 && !busy[2]) ar_idle++;
        if (cnt[2]) ar_cnt++;
        if (ld[2]) ar_ld++;
        if (c == 5) check("ar_wraps1", wraps[2], 1);
        if (c == 9) check("ar_wraps2", wraps[2], 2);
        if (c == 13) check("ar_wraps3", wraps[2], 3);
        step();
      end
      start[2] = 1'b0; abort[2] = 1'b0;
      #1;
      check("ar_done_n", ar_done, 0);
      check("ar_busy_gaps", ar_idle, 0);
      check("ar_cnt_n", ar_cnt, 10);
      check("ar_ld_n", ar_ld, 6);
      check("ar_busy_after_abort", busy[2], 0);
    end
`endif

    // Reset mid-RUN: outputs clear immediately, no restart without start
    num[0] = 4'd1; dir_up[0] = 1'b0; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    step(); step(); step(); step();
    #1;
    check("mr_busy_before", busy[0], 1);
    #2;
    clr = 1'b0;
    #1;
    check("mr_busy", busy[0], 0);
    check("mr_ld", ld[0], 0);
    check("mr_cnt", cnt[0], 0);
    check("mr_done", done[0], 0);
    check("mr_up", up[0], 1);
    check("mr_wraps", wraps[0], 0);
    step();
    clr = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("mr_idle_busy", busy[0], 0);
    check("mr_idle_ld", ld[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ud_counter_ctrl.md
Name: ud_counter_ctrl

Overview:
- Initiator-side sequencer for a ud_counter_block chain: generates ld, cnt and up, and consumes the chain's tc.
- Starts a counting round on request and paces count enables with an internal prescaler.
- Stops the round when terminal count is reached and reports completion to game logic.
- Sits between the round/game FSM and the digit counters.

Parameters:
- PRESCALE, 4, inter_clk cycles per count tick (>=1); 1 gives a tick every cycle.
- PSC_W, 16, prescaler counter width; PRESCALE-1 must fit.
- WRAP_W, 8, width of the wrap-count output.

Ports:
- inter_clk  in  1  clock.
- clr  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a round; ignored unless IDLE.
- abort  in  1  level; returns the FSM to IDLE without done.
- pause  in  1  level; freezes counting in RUN.
- dir_up  in  1  direction, sampled on accepted start.
- tc  in  1  terminal count from the counter chain (combinational in the counter).
- ld  out  1  counter load strobe.
- cnt  out  1  counter count enable.
- up  out  1  counter direction.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse at round completion.
- wraps  out  WRAP_W  number of auto-reloads in the current round.

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE, psc=0, up=1, wraps=0; ld, cnt, busy and done all 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - start=1 and abort=0 -> LOAD; up<=dir_up, wraps<=0.
  - start and abort in the same cycle: abort wins, stay IDLE.
- LOAD:
  - ld=1 for exactly one cycle, then RUN; psc<=0.
  - abort in LOAD -> IDLE.
- RUN:
  - Prescaler: psc increments each cycle while pause=0 and wraps to 0 at PRESCALE-1. tick = (psc==PRESCALE-1) & !pause.
  - pause=1 holds psc, forces cnt=0 and keeps the state.
  - At a tick with tc=0: cnt=1 for that cycle.
  - At a tick with tc=1: cnt=0, next state DONE. The counter therefore rests on its terminal value.
  - cnt is combinational: (state==RUN) & tick & !tc. ld, busy and done are decoded from registered state only.
  - abort in RUN -> IDLE next cycle; cnt=0 in the abort cycle; the counter value is left untouched.
- DONE: done=1 for one cycle, then IDLE. abort has no effect in DONE; start in DONE is ignored.
- Round length: first cnt pulse PRESCALE cycles after entry to RUN. A round with K steps to terminal takes 1 (LOAD) + (K+1)*PRESCALE cycles to reach DONE.
- up is constant from LOAD until the next accepted start, so tc polarity is stable for the whole round.
- PRESCALE=1: tick every unpaused cycle in RUN.
- wraps saturates at all-ones and holds until the next accepted start.

Optional Feature:
- Macro: UD_CTRL_AUTO_RELOAD_EN.
- Defined: a tick with tc=1 in RUN goes to LOAD instead of DONE, wraps increments (saturating), and the round continues until abort. done never pulses; busy stays 1.
- Not defined: behaviour as above, and wraps is tied to 0.

Decomposition:
- Shared package ud_counter_pkg holds:
  - state enum: IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3;
  - default PRESCALE;
  - 4-bit digit width constant, shared with ud_counter_block.
- One natural sub-module, ud_tick_gen: the prescaler with enable, hold and sync clear, outputting tick.

Test Plan:
- Reset mid-RUN: drop clr asynchronously -> all outputs 0 immediately, state IDLE; after release, start is required to run again.
- Count-up round: PRESCALE=4, counter num=1, dir_up=1, start -> ld pulse at cycle 1, 14 cnt pulses spaced 4 cycles apart, counter ends at 15, done pulse at cycle 1+15*4+1, busy low afterwards.
- Count-down with pause: dir_up=0, num=1, PRESCALE=2, pause held 10 cycles after the first cnt -> counter at 0 after the first cnt, no cnt during pause, done 2 cycles after pause release, no underflow to 15.
- Abort and start/abort collision:
  - abort asserted after the 3rd cnt -> no further cnt, no done, counter stays at num+3, busy=0 next cycle.
  - start and abort together in IDLE -> stays IDLE.
- PRESCALE=1, num=15, dir_up=1 -> ld, then the first RUN cycle sees tc=1 -> zero cnt pulses, done at cycle 3.
- With UD_CTRL_AUTO_RELOAD_EN: num=13, dir_up=1, PRESCALE=1 -> repeating ld and two-cnt sequence; wraps=1, 2, 3...; done stays 0; abort returns to IDLE.
